// File: rtl/fft_pkg.sv
// Shared definitions for the fft frame sequencer: controller states and
// the default core geometry.
package fft_pkg;

  localparam int WIDTH = 16;
  localparam int N_2   = 5;
  localparam int N     = 2 ** N_2;
  localparam int IN_W  = WIDTH - 5;

  typedef enum logic [2:0] {
    RST_FFT,
    LOAD,
    START,
    WAIT,
    CAPTURE,
    DRAIN
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample-in and spectrum-out valid/ready streams of the frame sequencer.
// The slave modport is the sequencer side, the master modport the environment.
interface fft_frame_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int N_2   = 5
);

  localparam int IN_W = WIDTH - 5;

  logic                 s_valid;
  logic                 s_ready;
  logic [IN_W-1:0]      s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [2*WIDTH-1:0]   m_data;
  logic [N_2-1:0]       m_index;
  logic                 m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_index, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_index, m_last
  );

endinterface

// File: rtl/fft_frame_buf.sv
// Result frame store: one synchronous write port and a combinational read,
// so the replayed word stays put while the consumer stalls.
module fft_frame_buf #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdata;
  end

  assign rdata = mem[radr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around an fft core: loads N samples, starts the transform,
// captures the N result words after done and replays them as a stream.
module fft_frame_ctrl #(
  parameter int WIDTH  = 16,
  parameter int N_2    = 5,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_frame_ctrl_if.slave     bus,
  output logic                busy,
  output logic                fft_reset,
  output logic                fft_start,
  output logic                fft_load,
  output logic [WIDTH-1:0]    fft_rd,
  input  logic [2*WIDTH-1:0]  fft_wd,
  input  logic                fft_done
);

  import fft_pkg::*;

  localparam int FRAME_N = 2 ** N_2;
  localparam int CW      = $clog2(FRAME_N + RD_LAT + 1);

  fft_ctrl_state_t     state, state_next;
  logic [N_2-1:0]      ld_cnt, rd_idx;
  logic [CW-1:0]       cap_cnt, cap_eff;
  logic                cap_active, buf_we, last_write;
  logic [N_2-1:0]      buf_wadr;
  logic [2*WIDTH-1:0]  buf_rdata;
  logic                s_hs, m_hs;
  logic                s_ready_c, m_valid_c, m_last_c;

  assign s_hs = bus.s_valid & s_ready_c;
  assign m_hs = m_valid_c & bus.m_ready;

  // The first done cycle is still WAIT but already counts as capture cycle 0,
  // which lets a zero-latency core deliver word 0 in that same cycle.
  assign cap_active = (state == CAPTURE) | ((state == WAIT) & fft_done);
  assign cap_eff    = (state == CAPTURE) ? cap_cnt : '0;
  assign buf_we     = cap_active & (cap_eff >= CW'(RD_LAT));
  assign buf_wadr   = N_2'(cap_eff - CW'(RD_LAT));
  assign last_write = buf_we & (cap_eff == CW'(RD_LAT + FRAME_N - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RST_FFT;
      ld_cnt  <= '0;
      cap_cnt <= '0;
      rd_idx  <= '0;
    end else begin
      state   <= state_next;
      cap_cnt <= cap_active ? cap_eff + 1'b1 : '0;
      if (state == RST_FFT) begin
        ld_cnt <= '0;
        rd_idx <= '0;
      end else begin
        if (s_hs) ld_cnt <= ld_cnt + 1'b1;
        if (m_hs) rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Outputs are gated by reset_n so they show reset values while it is low.
  always_comb begin
    state_next = state;
    s_ready_c  = reset_n & (state == LOAD);
    m_valid_c  = reset_n & (state == DRAIN);
    m_last_c   = m_valid_c & (rd_idx == N_2'(FRAME_N - 1));
    busy       = ~s_ready_c;
    fft_reset  = ~reset_n | (state == RST_FFT);
    fft_start  = reset_n & (state == START);
    case (state)
      RST_FFT: state_next = LOAD;
      LOAD:    if (s_hs && ld_cnt == N_2'(FRAME_N - 1)) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (fft_done) state_next = CAPTURE;
      CAPTURE: if (last_write) state_next = DRAIN;
      DRAIN:   if (m_hs && m_last_c) state_next = RST_FFT;
      default: state_next = RST_FFT;
    endcase
  end

  assign fft_load    = s_hs;
  assign fft_rd      = {{5{bus.s_data[WIDTH-6]}}, bus.s_data};
  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_last  = m_last_c;
  assign bus.m_data  = m_valid_c ? buf_rdata : '0;
  assign bus.m_index = m_valid_c ? rd_idx : '0;

  fft_frame_buf #(
    .DW (2 * WIDTH),
    .AW (N_2)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .wadr  (buf_wadr),
    .wdata (fft_wd),
    .radr  (rd_idx),
    .rdata (buf_rdata)
  );

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer that drives the `fft` core from both ends. It accepts a valid/ready stream of real samples and loads exactly N of them into the core. It then starts the transform, waits for `done`, and captures the N free-running result words into a local frame buffer. Finally it replays those words as a backpressurable valid/ready stream, then re-arms the core for the next frame. It sits between the sample source and the spectrum consumer, wrapping one `fft` instance; it does not instantiate it.

## Interface
- WIDTH, 16, FFT word width per real/imag half; matches `fft` width
- N_2, 5, log2 of FFT points; N = 2**N_2
- RD_LAT, 1, cycles from `fft_done`/out-index change to corresponding `fft_wd` word (0 = combinational RAM read)
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid & s_ready
- s_data  in  WIDTH-5  signed real sample (headroom for N_2 stages of bit growth)
- m_valid  out  1  result word valid
- m_ready  in  1  consumer ready
- m_data  out  2*WIDTH  {re, im} result, natural bin order
- m_index  out  N_2  bin number of m_data
- m_last  out  1  high with bin N-1
- busy  out  1  high in every state except LOAD
- fft_reset  out  1  active-high reset to core
- fft_start  out  1  one-cycle start pulse
- fft_load  out  1  core load strobe
- fft_rd  out  WIDTH  core real input
- fft_wd  in  2*WIDTH  core result data
- fft_done  in  1  core done level

## Operation
- States: RST_FFT, LOAD, START, WAIT, CAPTURE, DRAIN.
- `reset_n`=0: state <= RST_FFT, counters <= 0. `fft_reset` = ~reset_n | (state==RST_FFT), so the core is held in reset while reset_n is low.
- RST_FFT: one cycle, then go to LOAD. This re-zeroes the core's loader index, level and out index.
- LOAD: s_ready=1.
  - fft_load = s_valid & s_ready, combinational; fft_rd = sign-extended s_data.
  - ld_cnt increments per handshake.
  - On the N-th handshake: s_ready deasserts the next cycle and the state goes to START.
  - fft_load is never high outside LOAD.
- START: fft_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until fft_done=1. The first cycle fft_done is sampled high is cycle T; that cycle enters CAPTURE with cap_cnt=0 already counting.
- CAPTURE: cap_cnt counts every cycle from T.
  - When cap_cnt = RD_LAT+k, fft_wd is written to buf[k], for k = 0..N-1.
  - After writing k=N-1, go to DRAIN.
  - No backpressure toward the core; s_ready=0.
- DRAIN: m_valid=1, m_data=buf[rd_idx], m_index=rd_idx, m_last=(rd_idx==N-1).
  - rd_idx advances on m_valid & m_ready.
  - The handshake with m_last goes to RST_FFT.
- Output stream rules:
  - m_data, m_index and m_last are stable while m_valid & ~m_ready.
  - m_valid is low outside DRAIN.
- Reset mid-frame, in any state: the partial frame is discarded, no m_last is emitted, and the next frame starts clean.
- Width rule: fft_rd = {{5{s_data[WIDTH-6]}}, s_data}. Results pass through unmodified.

## Timing
- Reset values, with reset_n low: s_ready=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=1, fft_reset=1, fft_start=0, fft_load=0.
- First s_ready=1 occurs 2 cycles after reset_n rises (RST_FFT, then LOAD).
- Load phase: minimum N cycles.
- fft_start rises the cycle after the N-th load handshake.
- WAIT duration is set by the core: N_2·N/2 cycles after enable for the current core (80 for N=32).
- CAPTURE lasts RD_LAT+N cycles.
- First m_valid occurs the cycle after the last buffer write.
- DRAIN: minimum N cycles.
- Frame-to-frame gap (with m_ready=1 and s_valid=1): N + 1 + WAIT + RD_LAT + N + N + 1 cycles.
- fft_done dropping before CAPTURE ends is ignored, since the counter-driven capture continues.

## Structure
- Shared `fft_pkg`:
  - state enum `fft_ctrl_state_t`.
  - localparams N = 2**N_2, IN_W = WIDTH-5.
- Sub-module `fft_frame_buf`:
  - N × 2*WIDTH register array.
  - One write port (we, wadr, wdata) and a combinational read (radr → rdata).
  - Keeps m_data stable under backpressure without skid logic.
- The controller holds the FSM, ld_cnt, cap_cnt and rd_idx.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → all outputs at reset values, fft_reset=1 throughout. s_ready=1 exactly 2 cycles after release.
- Stub core (done 10 cycles after start, wd={idx,~idx}, RD_LAT=1); feed N samples; m_ready=1 → bins 0..31 emerge in order.
  - m_data = {k, ~k} for each bin k.
  - m_last only at k=31.
  - fft_reset pulses once afterwards.
- Sample gaps: s_valid pattern 1,0,0,1 repeated → fft_load high only on the 32 handshake cycles, fft_rd matches each accepted s_data, fft_start one cycle after the 32nd.
- Backpressure: m_ready alternating 1,0 → 32 words, none dropped or duplicated, m_data stable on stall cycles.
- Sign extension: s_data=11'h7FF (−1) → fft_rd=16'hFFFF. s_data=11'h3FF → fft_rd=16'h03FF.
- Reset mid-CAPTURE at cap_cnt=5 → next cycle m_valid=0, fft_reset=1. The next frame with the real `fft` core and DC input 100 gives bin 0 re=3200±32, other bins |re|,|im| ≤32.
